// File: rtl/ga23_pkg.sv
// Shared definitions for the GA23 tile fetcher: bus widths, attribute layout,
// FSM state encoding and the shifter-feed payload.
package ga23_pkg;

  localparam int unsigned GA23_MAP_W_LOG2 = 6;
  localparam int unsigned GA23_TILES      = 42;

  localparam int unsigned VRAM_AW = 16;
  localparam int unsigned VRAM_DW = 16;
  localparam int unsigned ROM_AW  = 22;
  localparam int unsigned ROM_DW  = 32;

  localparam int unsigned ATTR_PAL_LSB  = 0;
  localparam int unsigned ATTR_PAL_W    = 4;
  localparam int unsigned ATTR_FLIPX    = 5;
  localparam int unsigned ATTR_FLIPY    = 6;
  localparam int unsigned ATTR_PRIO_LSB = 7;
  localparam int unsigned ATTR_PRIO_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CODE  = 3'd1,
    ST_ATTR  = 3'd2,
    ST_ROW   = 3'd3,
    ST_READY = 3'd4
  } fetch_state_e;

  // One decoded tile as presented to the pixel shifter
  typedef struct packed {
    logic [ROM_DW-1:0]      row;
    logic [ATTR_PAL_W-1:0]  palette;
    logic [ATTR_PRIO_W-1:0] prio;
    logic                   reverse;
  } tile_feed_t;

endpackage

// File: rtl/ga23_tile_fetch_if.sv
// VRAM tilemap and graphics ROM request/ack channels of the tile fetcher.
interface ga23_tile_fetch_if;
  import ga23_pkg::*;

  logic               vram_req;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_ack;
  logic [VRAM_DW-1:0] vram_data;

  logic               rom_req;
  logic [ROM_AW-1:0]  rom_addr;
  logic               rom_ack;
  logic [ROM_DW-1:0]  rom_data;

  modport master (
    output vram_req, vram_addr, rom_req, rom_addr,
    input  vram_ack, vram_data, rom_ack, rom_data
  );

  modport slave (
    input  vram_req, vram_addr, rom_req, rom_addr,
    output vram_ack, vram_data, rom_ack, rom_data
  );

endinterface

// File: rtl/ga23_tile_fetch.sv
// Per-line tile fetcher: walks tilemap entries, fetches one graphics row per
// tile and hands it to the pixel shifter on every 8th pixel enable.
module ga23_tile_fetch
  import ga23_pkg::*;
#(
  parameter int unsigned TILES      = GA23_TILES,
  parameter int unsigned MAP_W_LOG2 = GA23_MAP_W_LOG2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic                   line_start,
  input  logic [8:0]             vpos,
  input  logic [9:0]             scroll_x,
  input  logic [9:0]             scroll_y,
  input  logic [VRAM_AW-1:0]     map_base,
  ga23_tile_fetch_if.master      mem,
  output logic                   load,
  output logic                   reverse,
  output logic [ROM_DW-1:0]      row,
  output logic [ATTR_PAL_W-1:0]  palette,
  output logic [ATTR_PRIO_W-1:0] prio,
  output logic [2:0]             offset,
  output logic                   underrun
);

  localparam int unsigned TW    = MAP_W_LOG2;
  localparam int unsigned CNT_W = $clog2(TILES + 1);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [2:0]         r_slot;
  logic [CNT_W-1:0]   r_cnt;
  logic [TW-1:0]      r_tx;
  logic [TW-1:0]      r_ty;
  logic [2:0]         r_fy;
  logic [VRAM_DW-1:0] r_code;
  tile_feed_t         r_fetch;
  tile_feed_t         r_feed;
  tile_feed_t         w_feed;
  logic               r_vram_req;
  logic [VRAM_AW-1:0] r_vram_addr;
  logic               r_rom_req;
  logic [ROM_AW-1:0]  r_rom_addr;
  logic               r_underrun;

  logic [9:0]         w_vsum;
  logic [TW-1:0]      w_ty_line;
  logic [2:0]         w_fy_line;
  logic [TW-1:0]      w_tx_line;
  logic [TW-1:0]      w_tx_inc;
  logic [VRAM_AW-1:0] w_entry_line;
  logic [VRAM_AW-1:0] w_entry_next;
  logic               w_slot;
  logic               w_take;
  logic               w_miss;
  logic               w_last;

  // Line geometry; map coordinates wrap at the map size in both axes
  assign w_vsum       = 10'(vpos) + scroll_y;
  assign w_ty_line    = TW'(w_vsum[9:3]);
  assign w_fy_line    = w_vsum[2:0];
  assign w_tx_line    = TW'(scroll_x[9:3]);
  assign w_tx_inc     = r_tx + TW'(1);
  assign w_entry_line = map_base + VRAM_AW'({w_ty_line, w_tx_line, 1'b0});
  assign w_entry_next = map_base + VRAM_AW'({r_ty, w_tx_inc, 1'b0});

  // A line_start in the same cycle supersedes any slot of the old line
  assign w_slot = ce_pix && !line_start && (r_slot == 3'd7) && (r_state != ST_IDLE);
  assign w_take = w_slot && (r_state == ST_READY);
  assign w_miss = w_slot && (r_state != ST_READY);
  assign w_last = (r_cnt == CNT_W'(TILES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = ST_CODE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_CODE:  if (mem.vram_ack) w_state_nxt = ST_ATTR;
        ST_ATTR:  if (mem.vram_ack) w_state_nxt = ST_ROW;
        ST_ROW:   if (mem.rom_ack)  w_state_nxt = ST_READY;
        ST_READY: if (w_take)       w_state_nxt = w_last ? ST_IDLE : ST_CODE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shifter feed: held tile on a ready slot, blank tile on a missed slot
  always_comb begin
    load   = 1'b0;
    w_feed = r_feed;
    if (w_slot) begin
      load   = 1'b1;
      w_feed = (r_state == ST_READY) ? r_fetch : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot      <= 3'd0;
      r_cnt       <= '0;
      r_tx        <= '0;
      r_ty        <= '0;
      r_fy        <= 3'd0;
      r_code      <= '0;
      r_fetch     <= '0;
      r_feed      <= '0;
      r_vram_req  <= 1'b0;
      r_vram_addr <= '0;
      r_rom_req   <= 1'b0;
      r_rom_addr  <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (line_start)  r_slot <= 3'd0;
      else if (ce_pix) r_slot <= r_slot + 3'd1;

      if (w_slot) r_feed     <= w_feed;
      if (w_miss) r_underrun <= 1'b1;

      if (line_start) begin
        r_cnt       <= '0;
        r_tx        <= w_tx_line;
        r_ty        <= w_ty_line;
        r_fy        <= w_fy_line;
        r_vram_req  <= 1'b1;
        r_vram_addr <= w_entry_line;
        r_rom_req   <= 1'b0;
      end else begin
        case (r_state)
          ST_CODE: begin
            if (mem.vram_ack) begin
              r_code      <= mem.vram_data;
              r_vram_addr <= r_vram_addr + VRAM_AW'(1);
            end
          end
          ST_ATTR: begin
            if (mem.vram_ack) begin
              r_fetch.palette <= mem.vram_data[ATTR_PAL_LSB +: ATTR_PAL_W];
              r_fetch.prio    <= mem.vram_data[ATTR_PRIO_LSB +: ATTR_PRIO_W];
              r_fetch.reverse <= mem.vram_data[ATTR_FLIPX];
              r_rom_addr      <= ROM_AW'({r_code, r_fy ^ {3{mem.vram_data[ATTR_FLIPY]}}});
              r_vram_req      <= 1'b0;
              r_rom_req       <= 1'b1;
            end
          end
          ST_ROW: begin
            if (mem.rom_ack) begin
              r_fetch.row <= mem.rom_data;
              r_rom_req   <= 1'b0;
            end
          end
          ST_READY: begin
            if (w_take) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (!w_last) begin
                r_tx        <= w_tx_inc;
                r_vram_addr <= w_entry_next;
                r_vram_req  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem.vram_req  = r_vram_req;
  assign mem.vram_addr = r_vram_addr;
  assign mem.rom_req   = r_rom_req;
  assign mem.rom_addr  = r_rom_addr;

  assign row      = w_feed.row;
  assign palette  = w_feed.palette;
  assign prio     = w_feed.prio;
  assign reverse  = w_feed.reverse;
  assign offset   = scroll_x[2:0];
  assign underrun = r_underrun;

endmodule

// File: tb/tb_ga23_tile_fetch.sv
// Directed bench for ga23_tile_fetch with a zero-wait VRAM model and a
// programmable-latency ROM model.
module tb_ga23_tile_fetch;

  logic        clk;
  logic        reset;
  logic        ce_pix;
  logic        line_start;
  logic [8:0]  vpos;
  logic [9:0]  scroll_x;
  logic [9:0]  scroll_y;
  logic [15:0] map_base;
  logic        load;
  logic        reverse;
  logic [31:0] row;
  logic [3:0]  palette;
  logic [1:0]  prio;
  logic [2:0]  offset;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int rom_delay = 0;
  int r_wait;

  logic [15:0] vmem [0:65535];

  ga23_tile_fetch_if bus ();

  ga23_tile_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .line_start (line_start),
    .vpos       (vpos),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .map_base   (map_base),
    .mem        (bus),
    .load       (load),
    .reverse    (reverse),
    .row        (row),
    .palette    (palette),
    .prio       (prio),
    .offset     (offset),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.vram_ack  = bus.vram_req;
  assign bus.vram_data = vmem[bus.vram_addr];
  assign bus.rom_ack   = bus.rom_req && (r_wait >= rom_delay);
  assign bus.rom_data  = 32'(bus.rom_addr) ^ 32'hA500_0000;

  always_ff @(posedge clk) begin
    if (bus.rom_req && !bus.rom_ack) r_wait <= r_wait + 1;
    else                             r_wait <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int loads;
    int last;
    int gap_bad;
    int vreq_seen;

    for (int i = 0; i < 65536; i++) vmem[i] = 16'h0000;
    for (int k = 0; k < 64; k++) vmem[2*k] = 16'h0100 + 16'(k);
    vmem[1]       = 16'h0025;
    vmem[3]       = 16'h01C0;
    vmem[16'h117E] = 16'h0ABC;

    reset = 1'b1; ce_pix = 1'b1; line_start = 1'b0;
    vpos = '0; scroll_x = '0; scroll_y = '0; map_base = '0;
    adv(3);
    chk("rst_load",     64'(load),         64'h0);
    chk("rst_vreq",     64'(bus.vram_req), 64'h0);
    chk("rst_rreq",     64'(bus.rom_req),  64'h0);
    chk("rst_row",      64'(row),          64'h0);
    chk("rst_underrun", 64'(underrun),     64'h0);
    reset = 1'b0;
    adv(2);

    // Line 1: map 0, no scroll, zero-wait memories
    line_start = 1'b1;
    adv(1); line_start = 1'b0;
    chk("t1_vreq",   64'(bus.vram_req),  64'h1);
    chk("t1_vaddr0", 64'(bus.vram_addr), 64'h0);
    adv(1);
    chk("t1_vaddr1", 64'(bus.vram_addr), 64'h1);
    adv(1);
    chk("t1_rreq",   64'(bus.rom_req),   64'h1);
    chk("t1_raddr0", 64'(bus.rom_addr),  64'h800);
    adv(4);
    chk("t1_noload_early", 64'(load), 64'h0);
    adv(1);
    chk("t1_load0",  64'(load),    64'h1);
    chk("t1_row0",   64'(row),     64'hA500_0800);
    chk("t1_pal0",   64'(palette), 64'h5);
    chk("t1_rev0",   64'(reverse), 64'h1);
    chk("t1_prio0",  64'(prio),    64'h0);
    adv(1);
    chk("t1_load_off", 64'(load),          64'h0);
    chk("t1_row_hold", 64'(row),           64'hA500_0800);
    chk("t1_vaddr2",   64'(bus.vram_addr), 64'h2);
    adv(2);
    chk("t1_raddr1", 64'(bus.rom_addr), 64'h80F);
    adv(5);
    chk("t1_load1",  64'(load),    64'h1);
    chk("t1_row1",   64'(row),     64'hA500_080F);
    chk("t1_prio1",  64'(prio),    64'h3);
    chk("t1_pal1",   64'(palette), 64'h0);
    chk("t1_rev1",   64'(reverse), 64'h0);
    loads = 2; last = 15; gap_bad = 0;
    for (int c = 16; c <= 380; c++) begin
      adv(1);
      if (load) begin
        loads++;
        if (c - last != 8) gap_bad++;
        last = c;
      end
    end
    chk("t1_load_count", 64'(loads),        64'd42);
    chk("t1_load_gaps",  64'(gap_bad),      64'd0);
    chk("t1_underrun",   64'(underrun),     64'h0);
    chk("t1_idle_vreq",  64'(bus.vram_req), 64'h0);

    // Line 2: scrolled, x wraps at map edge, pixel enable held off 5 clocks
    map_base = 16'h1000; scroll_x = 10'h3FD; scroll_y = 10'h00C; vpos = 9'd5;
    ce_pix = 1'b0; line_start = 1'b1;
    #1;
    chk("t2_offset", 64'(offset), 64'h5);
    adv(1); line_start = 1'b0;
    chk("t2_vaddr0", 64'(bus.vram_addr), 64'h117E);
    adv(2);
    chk("t2_raddr0", 64'(bus.rom_addr), 64'h55E1);
    adv(3); ce_pix = 1'b1;
    adv(6);
    chk("t2_noload", 64'(load), 64'h0);
    adv(1);
    chk("t2_load",   64'(load), 64'h1);
    chk("t2_row",    64'(row),  64'hA500_55E1);
    adv(1);
    chk("t2_vaddr_wrap", 64'(bus.vram_addr), 64'h1100);

    // Line 3 restarted by a new line_start while a ROM request is pending
    rom_delay = 50; line_start = 1'b1;
    adv(1); line_start = 1'b0;
    adv(2);
    chk("t3_rreq_pending", 64'(bus.rom_req), 64'h1);
    map_base = 16'h0000; scroll_x = '0; scroll_y = '0; vpos = '0;
    rom_delay = 12; line_start = 1'b1;
    adv(1); line_start = 1'b0;
    chk("t3_vreq",  64'(bus.vram_req),  64'h1);
    chk("t3_vaddr", 64'(bus.vram_addr), 64'h0);
    chk("t3_rreq",  64'(bus.rom_req),   64'h0);

    // Slow ROM: first slot misses, tile arrives at the following slot
    adv(7);
    chk("t4_miss_load",   64'(load),     64'h1);
    chk("t4_miss_row",    64'(row),      64'h0);
    chk("t4_miss_pal",    64'(palette),  64'h0);
    chk("t4_miss_rev",    64'(reverse),  64'h0);
    chk("t4_underrun_pre", 64'(underrun), 64'h0);
    adv(1);
    chk("t4_underrun",    64'(underrun), 64'h1);
    adv(7);
    chk("t4_late_load",   64'(load),     64'h1);
    chk("t4_late_row",    64'(row),      64'hA500_0800);
    chk("t4_late_pal",    64'(palette),  64'h5);

    // Reset while fetching the attribute word
    rom_delay = 0; line_start = 1'b1;
    adv(1); line_start = 1'b0;
    adv(1); reset = 1'b1;
    adv(1); reset = 1'b0;
    chk("t5_vreq",     64'(bus.vram_req), 64'h0);
    chk("t5_rreq",     64'(bus.rom_req),  64'h0);
    chk("t5_load",     64'(load),         64'h0);
    chk("t5_row",      64'(row),          64'h0);
    chk("t5_pal",      64'(palette),      64'h0);
    chk("t5_prio",     64'(prio),         64'h0);
    chk("t5_rev",      64'(reverse),      64'h0);
    chk("t5_underrun", 64'(underrun),     64'h0);
    loads = 0; vreq_seen = 0;
    for (int c = 0; c < 24; c++) begin
      adv(1);
      if (load) loads++;
      if (bus.vram_req) vreq_seen++;
    end
    chk("t5_no_load", 64'(loads),     64'd0);
    chk("t5_no_vreq", 64'(vreq_seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
